// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch widths, reset PC and the fetch->decode payload.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned FETCH_DEPTH = 2;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a single-cycle flush; head is read combinationally.
module fetch_fifo #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush empties the queue in one cycle.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: PC register, imem addressing and skid FIFO to decode.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned       INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter int unsigned       DEPTH    = cpu_pkg::FETCH_DEPTH
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               fetch_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    localparam int unsigned CNT_W   = $clog2(DEPTH+1);
    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0]  pc;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head_data;
    logic               pop_c;
    logic               push_c;

    // Handshake and push qualification; redirect suppresses the push.
    always_comb begin
        pop_c  = 1'b0;
        push_c = 1'b0;
        pop_c  = out_valid && out_ready;
        push_c = fetch_en && !redirect && ((count < CNT_W'(DEPTH)) || pop_c);
    end

    // Program counter: reset, then redirect, then sequential advance on push.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (push_c) begin
            pc <= pc + ADDR_W'(1);
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (redirect),
        .push      (push_c),
        .push_data ({pc, imem_data}),
        .pop       (pop_c),
        .head_data (head_data),
        .count     (count)
    );

    // Head presentation; zeroed while the FIFO is empty.
    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_instr = '0;
        imem_addr = pc;
        if (count != '0) begin
            out_valid = 1'b1;
            out_pc    = head_data[ENTRY_W-1 -: ADDR_W];
            out_instr = head_data[INSTR_W-1:0];
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch against a queue-based reference model.
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fetch_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;

    logic [31:0] mem [256];

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] instr;
    } ent_t;

    ent_t       q[$];
    logic [7:0] m_pc;
    int         checks = 0;
    int         passed = 0;

    logic [48:0] dut_bus;

    always #5 clock = ~clock;

    assign imem_data = mem[imem_addr];
    assign dut_bus   = {out_valid, out_pc, out_instr, imem_addr};

    instr_fetch dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .fetch_en    (fetch_en),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
    );

    // Expected {out_valid, out_pc, out_instr, imem_addr} from the model.
    function automatic logic [48:0] exp_bus();
        if (q.size() == 0) return {1'b0, 8'd0, 32'd0, m_pc};
        return {1'b1, q[0].pc, q[0].instr, m_pc};
    endfunction

    // Advance model by one clock using the current inputs, then the DUT.
    task automatic tick();
        bit pop;
        bit push;
        if (!reset_n) begin
            q.delete();
            m_pc = 8'd0;
        end else begin
            pop  = (q.size() > 0) && out_ready;
            push = fetch_en && !redirect && ((q.size() < 2) || pop);
            if (redirect) begin
                q.delete();
                m_pc = redirect_pc;
            end else begin
                if (pop) void'(q.pop_front());
                if (push) begin
                    q.push_back('{pc: m_pc, instr: mem[m_pc]});
                    m_pc = m_pc + 8'd1;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; fetch_en = 1'b1; redirect = 1'b0; redirect_pc = 8'd0; out_ready = 1'b1;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
        checks++; if (out_pc !== 8'd0) $display("FAIL reset_pc: got %0d want 0", out_pc); else passed++;
        checks++; if (out_instr !== 32'd0) $display("FAIL reset_instr: got %h want 0", out_instr); else passed++;
        checks++; if (imem_addr !== 8'd0) $display("FAIL reset_addr: got %0d want 0", imem_addr); else passed++;
    endtask

    task automatic test_streaming();
        reset_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1) $display("FAIL first_valid: got %b want 1", out_valid); else passed++;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_pc !== 8'(i) || out_instr !== 32'hA000_0000 + 32'(i))
                $display("FAIL stream_%0d: got pc=%0d instr=%h want pc=%0d instr=%h", i, out_pc, out_instr, i, 32'hA000_0000 + 32'(i));
            else passed++;
            checks++; if (dut_bus !== exp_bus()) $display("FAIL stream_model_%0d: got %h want %h", i, dut_bus, exp_bus()); else passed++;
            tick();
        end
    endtask

    task automatic test_backpressure();
        redirect = 1'b1; redirect_pc = 8'd0; tick();
        redirect = 1'b0; tick();
        while (out_pc !== 8'd3 && checks < 100000) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (dut_bus !== exp_bus()) $display("FAIL bp_hold_%0d: got %h want %h", i, dut_bus, exp_bus()); else passed++;
        end
        checks++; if (imem_addr !== 8'd5) $display("FAIL bp_addr: got %0d want 5", imem_addr); else passed++;
        checks++; if (out_pc !== 8'd3 || out_valid !== 1'b1) $display("FAIL bp_head: got pc=%0d v=%b want pc=3 v=1", out_pc, out_valid); else passed++;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (out_pc !== 8'(3 + j) || out_valid !== 1'b1) $display("FAIL bp_release_%0d: got pc=%0d v=%b want pc=%0d", j, out_pc, out_valid, 3 + j);
            else passed++;
            tick();
        end
    endtask

    task automatic test_redirect_full();
        out_ready = 1'b0;
        tick(); tick();
        checks++; if (dut_bus !== exp_bus()) $display("FAIL rf_full: got %h want %h", dut_bus, exp_bus()); else passed++;
        redirect = 1'b1; redirect_pc = 8'd33;
        tick();
        checks++; if (out_valid !== 1'b0 || imem_addr !== 8'd33) $display("FAIL rf_flush: got v=%b addr=%0d want v=0 addr=33", out_valid, imem_addr); else passed++;
        redirect = 1'b0; out_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_pc !== 8'(33 + k) || out_instr !== 32'hA000_0000 + 32'(33 + k))
                $display("FAIL rf_target_%0d: got pc=%0d instr=%h want pc=%0d", k, out_pc, out_instr, 33 + k);
            else passed++;
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        redirect = 1'b1; redirect_pc = 8'd254; tick();
        redirect = 1'b0; tick();
        for (int k = 0; k < 4; k++) begin
            e = 8'd254 + 8'(k);
            checks++;
            if (out_pc !== e || out_valid !== 1'b1) $display("FAIL wrap_%0d: got pc=%0d v=%b want pc=%0d", k, out_pc, out_valid, e);
            else passed++;
            tick();
        end
    endtask

    task automatic test_fetch_en();
        logic [7:0] held;
        held = imem_addr;
        fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (imem_addr !== held) $display("FAIL fe_frozen: got %0d want %0d", imem_addr, held); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL fe_drained: got v=%b want 0", out_valid); else passed++;
        fetch_en = 1'b1; tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== held) $display("FAIL fe_resume: got v=%b pc=%0d want v=1 pc=%0d", out_valid, out_pc, held); else passed++;
        redirect = 1'b1; redirect_pc = 8'd100;
        tick();
        checks++; if (out_valid !== 1'b0 || imem_addr !== 8'd100) $display("FAIL fe_redir_pop: got v=%b addr=%0d want v=0 addr=100", out_valid, imem_addr); else passed++;
        redirect = 1'b0; tick();
        checks++; if (out_pc !== 8'd100 || out_valid !== 1'b1) $display("FAIL fe_redir_target: got pc=%0d v=%b want pc=100 v=1", out_pc, out_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        int n;
        redirect = 1'b1; redirect_pc = 8'd37; tick();
        redirect = 1'b0;
        n = 0;
        while (imem_addr !== 8'd40 && n < 10) begin tick(); n++; end
        checks++; if (imem_addr !== 8'd40) $display("FAIL rm_reach40: got %0d want 40", imem_addr); else passed++;
        reset_n = 1'b0; tick();
        checks++; if (out_valid !== 1'b0 || imem_addr !== 8'd0) $display("FAIL rm_reset: got v=%b addr=%0d want v=0 addr=0", out_valid, imem_addr); else passed++;
        reset_n = 1'b1; tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 8'd0) $display("FAIL rm_restart: got v=%b pc=%0d want v=1 pc=0", out_valid, out_pc); else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        for (int c = 0; c < 600; c++) begin
            reset_n     = ($urandom_range(0, 99) != 0);
            fetch_en    = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = 8'($urandom);
            out_ready   = ($urandom_range(0, 2) != 0);
            tick();
            checks++; if (dut_bus !== exp_bus()) $display("FAIL rand_%0d: got %h want %h", c, dut_bus, exp_bus()); else passed++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
        q.delete();
        m_pc = 8'd0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_full();
        test_wrap();
        test_fetch_en();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
